uart_tx_periph: RTL and testbench
=================================

// Module: uart_tx_periph
// PURPOSE
//  Memory-mapped UART transmitter. It is a bus responder on the system bus, on the
//  far side of bus_controller from the riscv core, using the same slave port shape as gpio.
//  The CPU writes bytes into a TX FIFO. An 8N1 serializer drains the FIFO onto tx_o,
//  with a programmable baud divisor, status flags and a level interrupt.
// PARAMETERS
//  FIFO_DEPTH   8    TX FIFO entries; power of 2, range 2..16
//  DEFAULT_DIV  433  reset value of DIV (bit time = DIV+1 clk; 50 MHz -> 115200 baud)
// PORTS
//  clk     in   1   system clock (clk_50m domain)
//  rst     in   1   synchronous reset, active-high
//  sel_i   in   1   bus select for this peripheral, valid this cycle
//  we_i    in   4   byte write enables; 4'b0000 with sel_i means a read
//  addr_i  in   32  byte address; only addr_i[3:2] decoded (word offset)
//  data_i  in   32  write data
//  data_o  out  32  read data, registered
//  tx_o    out  1   serial output, idle high
//  irq_o   out  1   level interrupt: CTRL.ie & fifo_empty & ~busy
// BEHAVIOUR
//  Register map (addr_i[3:2]):
//   0 CTRL   [0] tx_en, [1] ie; rest read 0. Reset 0.
//   1 DIV    [15:0] divisor; rest read 0. Reset DEFAULT_DIV. Byte enables honoured.
//   2 TXDATA write with we_i[0]: push data_i[7:0]. Reads 0.
//   3 STATUS [0] busy, [1] full, [2] empty, [3] overflow (sticky, W1C via we_i[0]&data_i[3]),
//            [12:8] FIFO level. Other writes ignored.
//  Reads: data_o <= reg(addr_i[3:2]) the cycle after sel_i & we_i==0 (1-cycle latency,
//   same as data_mem). Otherwise data_o <= 0. Reads have no side effects.
//  Reset values: data_o=0, tx_o=1, irq_o=0 (ie=0), FIFO empty, overflow=0, FSM IDLE.
//  FIFO: wr/rd pointers of clog2(FIFO_DEPTH) bits wrap modulo depth; level counter 0..DEPTH.
//   - Push when full: byte dropped, overflow<=1, level unchanged.
//   - Push and pop in the same cycle when full: push accepted, level stays DEPTH, no overflow.
//   - Push and pop in the same cycle when empty: impossible (pop needs ~empty); push accepted.
//  FSM (IDLE, START, DATA, STOP), baud counter cnt, bit index 0..7:
//   IDLE : tx_o=1. If tx_en & ~empty: pop head into shift reg, latch DIV into div_q,
//          cnt<=0, go to START (tx_o low from the next cycle).
//   START: tx_o=0 for div_q+1 cycles, then go to DATA with bit=0.
//   DATA : tx_o=shift[0], LSB first. Each bit lasts div_q+1 cycles, then shift right.
//          After bit 7, go to STOP.
//   STOP : tx_o=1 for div_q+1 cycles, then go to IDLE. A back-to-back pop may
//          occur in the IDLE cycle, so the frame-to-frame gap is 1 clk.
//   busy = (state != IDLE).
//   Frame length = 10*(div_q+1) cycles.
//  - DIV written mid-frame: no effect until next frame start (div_q latched).
//  - DIV=0: bit time 1 clk; legal.
//  - tx_en cleared mid-frame: current frame completes, no further pops.
//  - tx_en set with FIFO non-empty: pop on the next IDLE cycle.
//  - rst mid-frame: next cycle tx_o=1, FIFO flushed, all registers to reset values.
//    The partial frame is abandoned.
// TESTING
//  1 Apply rst for 2 cycles, then read 0..3.
//    -> CTRL=0, DIV=433, TXDATA=0, STATUS=0x0000_0004; tx_o=1, irq_o=0.
//  2 Write DIV=3, CTRL=1, TXDATA=0x55.
//    -> tx_o=0 for 4 clk, then bits 1,0,1,0,1,0,1,0 at 4 clk each, then 1 for 4 clk.
//    -> busy set for 40 clk.
//  3 With tx_en=0, push 9 bytes 0x01..0x09.
//    -> STATUS level=8, full=1, overflow=1.
//    -> Enable: 0x01..0x08 are sent in order and 0x09 is never sent.
//  4 Keep FIFO full in IDLE and write TXDATA=0xA5 in the same cycle tx_en rises (pop).
//    -> level stays 8, overflow stays 0, 0xA5 is sent last.
//  5 DIV=9, send 0x0F, assert rst at cycle 25 of the frame.
//    -> tx_o=1 the next cycle, STATUS=0x4, DIV=433, no further tx_o activity.
//  6 ie=1, DIV=1, send one byte.
//    -> irq_o=0 while busy, irq_o=1 the cycle after STOP completes.
//    -> Writing STATUS with data_i=0x8 clears overflow only.

Source files
------------

// File: rtl/uart_tx_periph_if.sv
// ---------------------------------------------------------------------------
// uart_tx_periph_if
//   System-bus responder port shared by the memory-mapped peripherals.
//   One access per cycle: sel_i qualifies the cycle, a non-zero we_i is a
//   write with byte enables, we_i == 0 is a read whose data returns on
//   data_o one cycle later.
//
//   sel_i   bus select for this peripheral
//   we_i    byte write enables (4'b0000 = read)
//   addr_i  byte address
//   data_i  write data
//   data_o  registered read data
// ---------------------------------------------------------------------------
interface uart_tx_periph_if;
  logic        sel_i;
  logic [3:0]  we_i;
  logic [31:0] addr_i;
  logic [31:0] data_i;
  logic [31:0] data_o;

  modport master (
    output sel_i, we_i, addr_i, data_i,
    input  data_o
  );

  modport slave (
    input  sel_i, we_i, addr_i, data_i,
    output data_o
  );
endinterface

// File: rtl/uart_tx_periph.sv
// ---------------------------------------------------------------------------
// uart_tx_periph
//   Memory-mapped 8N1 UART transmitter. The CPU pushes bytes into a TX FIFO
//   through TXDATA; a serializer drains the FIFO onto tx_o using a
//   programmable baud divisor (bit time = DIV+1 clk).
//
//   Register map (addr_i[3:2]):
//     0 CTRL   [0] tx_en, [1] ie
//     1 DIV    [15:0] divisor, byte enables honoured
//     2 TXDATA write pushes data_i[7:0]; reads 0
//     3 STATUS [0] busy, [1] full, [2] empty, [3] overflow (W1C),
//              [12:8] FIFO level
//
//   Ports:
//     clk    system clock
//     rst    synchronous reset, active-high
//     bus    slave side of the system bus (sel_i/we_i/addr_i/data_i/data_o)
//     tx_o   serial output, idle high, registered
//     irq_o  level interrupt: ie & fifo empty & transmitter idle
// ---------------------------------------------------------------------------
module uart_tx_periph #(
  parameter int          FIFO_DEPTH  = 8,
  parameter logic [15:0] DEFAULT_DIV = 16'd433
) (
  input  logic             clk,
  input  logic             rst,
  uart_tx_periph_if.slave  bus,
  output logic             tx_o,
  output logic             irq_o
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FIFO_DEPTH);

  localparam logic [1:0] A_CTRL   = 2'd0;
  localparam logic [1:0] A_DIV    = 2'd1;
  localparam logic [1:0] A_TXDATA = 2'd2;
  localparam logic [1:0] A_STATUS = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  // -------------------------------------------------------------------------
  // Bus decode
  // -------------------------------------------------------------------------
  logic [1:0] word;
  logic       wr_en;
  logic       rd_en;

  assign word  = bus.addr_i[3:2];
  assign wr_en = bus.sel_i && (bus.we_i != 4'b0000);
  assign rd_en = bus.sel_i && (bus.we_i == 4'b0000);

  // Address/data bits this block never decodes.
  logic unused_bus_bits;
  assign unused_bus_bits = ^{bus.addr_i[31:4], bus.addr_i[1:0], bus.data_i[31:16]};

  // -------------------------------------------------------------------------
  // Control registers
  // -------------------------------------------------------------------------
  logic        tx_en;
  logic        ie;
  logic [15:0] div_r;
  logic        overflow;

  // -------------------------------------------------------------------------
  // TX FIFO
  // -------------------------------------------------------------------------
  logic [7:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [LVL_W-1:0] level;
  logic             fifo_full;
  logic             fifo_empty;
  logic             push_req;
  logic             push_ok;
  logic             pop;

  assign fifo_full  = (level == LVL_FULL);
  assign fifo_empty = (level == '0);
  assign push_req   = wr_en && (word == A_TXDATA) && bus.we_i[0];
  // A simultaneous pop frees the slot, so a push into a full FIFO still lands.
  assign push_ok    = push_req && (!fifo_full || pop);

  // NOTE: storage has no reset; emptiness is defined by level/pointers, so
  // stale contents are never observable and the array can map to plain RAM.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= bus.data_i[7:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      // Pointers are exactly clog2(depth) wide, so they wrap for free.
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)     rd_ptr <= rd_ptr + PTR_W'(1);
      unique case ({push_ok, pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Serializer FSM
  // -------------------------------------------------------------------------
  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] div_q, div_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shift_q, shift_d;
  logic        tx_q, tx_d;
  logic        busy;

  assign busy = (state_q != S_IDLE);

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      div_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    div_d   = div_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    pop     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (tx_en && !fifo_empty) begin
          pop     = 1'b1;
          shift_d = mem[rd_ptr];
          div_d   = div_r;   // divisor frozen for the whole frame
          cnt_d   = '0;
          state_d = S_START;
        end
      end
      S_START: begin
        if (cnt_q == div_q) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = S_DATA;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_DATA: begin
        if (cnt_q == div_q) begin
          cnt_d = '0;
          if (bit_q == 3'd7) begin
            state_d = S_STOP;
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = {1'b0, shift_q[7:1]};
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_STOP: begin
        if (cnt_q == div_q) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Line level is derived from the next state so tx_o comes straight
    // from a flop and changes exactly on state transitions.
    unique case (state_d)
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  assign tx_o  = tx_q;
  assign irq_o = ie && fifo_empty && !busy;

  // -------------------------------------------------------------------------
  // Register writes
  // -------------------------------------------------------------------------
  logic ovf_set;
  logic ovf_clr;

  assign ovf_set = push_req && fifo_full && !pop;
  assign ovf_clr = wr_en && (word == A_STATUS) && bus.we_i[0] && bus.data_i[3];

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_en    <= 1'b0;
      ie       <= 1'b0;
      div_r    <= DEFAULT_DIV;
      overflow <= 1'b0;
    end else begin
      if (wr_en && (word == A_CTRL) && bus.we_i[0]) begin
        tx_en <= bus.data_i[0];
        ie    <= bus.data_i[1];
      end
      if (wr_en && (word == A_DIV)) begin
        if (bus.we_i[0]) div_r[7:0]  <= bus.data_i[7:0];
        if (bus.we_i[1]) div_r[15:8] <= bus.data_i[15:8];
      end
      if (ovf_set) begin
        overflow <= 1'b1;
      end else if (ovf_clr) begin
        overflow <= 1'b0;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Read path: one-cycle latency, zero when not reading
  // -------------------------------------------------------------------------
  logic [31:0] rd_data;

  always_comb begin
    rd_data = '0;
    unique case (word)
      A_CTRL:   rd_data = {30'b0, ie, tx_en};
      A_DIV:    rd_data = {16'b0, div_r};
      A_TXDATA: rd_data = '0;
      A_STATUS: begin
        rd_data[0]    = busy;
        rd_data[1]    = fifo_full;
        rd_data[2]    = fifo_empty;
        rd_data[3]    = overflow;
        rd_data[12:8] = 5'(level);
      end
      default:  rd_data = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.data_o <= '0;
    end else begin
      bus.data_o <= rd_en ? rd_data : 32'h0;
    end
  end

endmodule

// File: tb/tb_uart_tx_periph.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_periph
//   Directed bench for uart_tx_periph. Bus cycles are driven on the falling
//   edge and outputs are sampled on the falling edge, half a period away
//   from the edge the DUT uses. Serial frames are decoded by sampling the
//   centre of each bit using the divisor the bench itself programmed.
// ---------------------------------------------------------------------------
module tb_uart_tx_periph;

  logic clk = 1'b0;
  logic rst;
  logic tx_o;
  logic irq_o;

  uart_tx_periph_if bus_if ();

  uart_tx_periph #(
    .FIFO_DEPTH  (8),
    .DEFAULT_DIV (16'd433)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .bus   (bus_if),
    .tx_o  (tx_o),
    .irq_o (irq_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [1:0] A_CTRL   = 2'd0;
  localparam logic [1:0] A_DIV    = 2'd1;
  localparam logic [1:0] A_TXDATA = 2'd2;
  localparam logic [1:0] A_STATUS = 2'd3;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic bus_idle();
    bus_if.sel_i  = 1'b0;
    bus_if.we_i   = 4'b0000;
    bus_if.addr_i = 32'h0;
    bus_if.data_i = 32'h0;
  endtask

  // Called at a falling edge; drives one bus cycle and returns at the next.
  task automatic bus_write(input logic [1:0] word, input logic [31:0] d,
                           input logic [3:0] be = 4'hF);
    bus_if.sel_i  = 1'b1;
    bus_if.we_i   = be;
    bus_if.addr_i = {28'h0, word, 2'b00};
    bus_if.data_i = d;
    @(negedge clk);
    bus_idle();
  endtask

  task automatic bus_read(input logic [1:0] word, output logic [31:0] d);
    bus_if.sel_i  = 1'b1;
    bus_if.we_i   = 4'b0000;
    bus_if.addr_i = {28'h0, word, 2'b00};
    bus_if.data_i = 32'h0;
    @(negedge clk);
    d = bus_if.data_o;
    bus_idle();
  endtask

  task automatic read_check(input string tag, input logic [1:0] word, input logic [31:0] exp);
    logic [31:0] d;
    bus_read(word, d);
    check(tag, d, exp);
  endtask

  // Advances falling edges until tx_o is low; bounded.
  task automatic wait_start(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (tx_o == 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
    check("frame_start_seen", 32'(ok), 32'd1);
  endtask

  // Decodes one frame. pre < 0: wait for the start bit. pre >= 0: the caller
  // is already at that cycle offset inside the start bit.
  task automatic recv_byte(input int div, input int pre, output logic [7:0] b);
    bit ok;
    int cyc;
    if (pre < 0) begin
      wait_start(ok);
      cyc = 0;
    end else begin
      cyc = pre;
    end
    repeat (div / 2 - cyc) @(negedge clk);
    check("start_bit", 32'(tx_o), 32'd0);
    for (int k = 0; k < 8; k++) begin
      repeat (div + 1) @(negedge clk);
      b[k] = tx_o;
    end
    repeat (div + 1) @(negedge clk);
    check("stop_bit", 32'(tx_o), 32'd1);
  endtask

  // Counts cycles with tx_o high over a window.
  task automatic idle_check(input string tag, input int n);
    int hi;
    hi = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (tx_o === 1'b1) hi++;
    end
    check(tag, 32'(hi), 32'(n));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  b;
    logic [7:0]  pat;
    logic        exp_tx;
    bit          ok;

    bus_idle();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // ---- 1: reset state -------------------------------------------------
    check("rst_tx_o",   32'(tx_o),  32'd1);
    check("rst_irq_o",  32'(irq_o), 32'd0);
    check("rst_data_o", bus_if.data_o, 32'h0);
    read_check("rst_ctrl",   A_CTRL,   32'h0000_0000);
    read_check("rst_div",    A_DIV,    32'd433);
    read_check("rst_txdata", A_TXDATA, 32'h0000_0000);
    read_check("rst_status", A_STATUS, 32'h0000_0004);

    // DIV byte enables: only the low byte changes (0x01B1 -> 0x0134).
    bus_write(A_DIV, 32'hFFFF_1234, 4'b0001);
    read_check("div_be0", A_DIV, 32'h0000_0134);
    // DIV bits [31:16] read back as 0 regardless of data_i.
    bus_write(A_DIV, 32'hABCD_0003);
    read_check("div_full", A_DIV, 32'h0000_0003);

    // ---- 2: one frame of 0x55 at DIV=3, cycle by cycle ------------------
    // ie is set too so irq_o mirrors ~busy while the FIFO is empty.
    bus_write(A_CTRL, 32'h3);
    check("irq_idle_empty", 32'(irq_o), 32'd1);
    bus_write(A_TXDATA, 32'h55);
    check("pre_frame_tx", 32'(tx_o), 32'd1);
    check("pre_frame_irq", 32'(irq_o), 32'd0);
    pat = 8'h55;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (i < 4)       exp_tx = 1'b0;
      else if (i < 36) exp_tx = pat[(i - 4) / 4];
      else             exp_tx = 1'b1;
      check($sformatf("f55_tx[%0d]", i), 32'(tx_o), 32'(exp_tx));
      check($sformatf("f55_busy[%0d]", i), 32'(irq_o), 32'd0);
    end
    @(negedge clk);
    check("f55_end_tx", 32'(tx_o), 32'd1);
    check("f55_end_irq", 32'(irq_o), 32'd1);

    // ---- 3: overflow, drop of the 9th byte, in-order drain --------------
    bus_write(A_CTRL, 32'h0);
    for (int i = 1; i <= 9; i++) bus_write(A_TXDATA, 32'(i));
    read_check("ovf_status", A_STATUS, 32'h0000_080A);
    bus_write(A_CTRL, 32'h1);
    for (int i = 1; i <= 8; i++) begin
      recv_byte(3, -1, b);
      check($sformatf("drain_byte%0d", i), 32'(b), 32'(i));
    end
    idle_check("no_ninth_byte", 60);
    read_check("drained_status", A_STATUS, 32'h0000_000C);
    bus_write(A_STATUS, 32'h8);
    read_check("ovf_cleared", A_STATUS, 32'h0000_0004);

    // ---- 4: push into full FIFO in the cycle of the first pop -----------
    bus_write(A_CTRL, 32'h0);
    for (int i = 0; i < 8; i++) bus_write(A_TXDATA, 32'h11 + 32'(i));
    read_check("full_status", A_STATUS, 32'h0000_0802);
    bus_write(A_CTRL, 32'h1);
    bus_write(A_TXDATA, 32'hA5);
    // Frame started one cycle ago: busy, level still 8, no overflow.
    read_check("pushpop_status", A_STATUS, 32'h0000_0803);
    recv_byte(3, 1, b);
    check("pp_byte0", 32'(b), 32'h11);
    for (int i = 1; i < 8; i++) begin
      recv_byte(3, -1, b);
      check($sformatf("pp_byte%0d", i), 32'(b), 32'h11 + 32'(i));
    end
    recv_byte(3, -1, b);
    check("pp_last_a5", 32'(b), 32'hA5);
    repeat (4) @(negedge clk);
    read_check("pp_done_status", A_STATUS, 32'h0000_0004);

    // ---- 5: reset in the middle of a DIV=9 frame ------------------------
    bus_write(A_DIV, 32'd9);
    bus_write(A_TXDATA, 32'h0F);
    wait_start(ok);
    repeat (5) @(negedge clk);
    check("mid_start_bit", 32'(tx_o), 32'd0);
    repeat (10) @(negedge clk);
    check("mid_bit0", 32'(tx_o), 32'd1);
    repeat (10) @(negedge clk);
    check("mid_bit1_c25", 32'(tx_o), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("post_rst_tx", 32'(tx_o), 32'd1);
    // Bits 4..7 of 0x0F would drive the line low if the frame continued.
    idle_check("post_rst_idle", 80);
    read_check("post_rst_status", A_STATUS, 32'h0000_0004);
    read_check("post_rst_div",    A_DIV,    32'd433);
    read_check("post_rst_ctrl",   A_CTRL,   32'h0000_0000);

    // ---- 6: overflow W1C leaves other state alone; irq timing -----------
    bus_write(A_CTRL, 32'h2);
    check("irq_ie_only", 32'(irq_o), 32'd1);
    for (int i = 0; i < 9; i++) bus_write(A_TXDATA, 32'h20 + 32'(i));
    check("irq_not_empty", 32'(irq_o), 32'd0);
    read_check("w1c_before", A_STATUS, 32'h0000_080A);
    bus_write(A_STATUS, 32'hFFFF_FFF7);
    read_check("w1c_no_bit3", A_STATUS, 32'h0000_080A);
    bus_write(A_STATUS, 32'h0000_0008);
    read_check("w1c_after", A_STATUS, 32'h0000_0802);

    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    bus_write(A_DIV, 32'd1);
    bus_write(A_CTRL, 32'h3);
    check("irq6_idle", 32'(irq_o), 32'd1);
    bus_write(A_TXDATA, 32'h3C);
    check("irq6_pushed", 32'(irq_o), 32'd0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check($sformatf("irq6_busy[%0d]", i), 32'(irq_o), 32'd0);
    end
    @(negedge clk);
    check("irq6_done", 32'(irq_o), 32'd1);
    check("irq6_done_tx", 32'(tx_o), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
